wb_grf: RTL and testbench
=========================

# wb_grf

Writeback-stage consumer of the M/W pipeline register, merged with the general register file. Each cycle it selects the writeback data from the W-stage fields, commits it to the 32×32 GPR array on the rising edge, and serves the two D-stage read ports. Read ports use write-through bypass, so a D-stage read in the same cycle as a W-stage write of the same register returns the new value. A retired-write counter supports bench and debug visibility.

## Interface
- LINK_OFFSET, default 4: added to PCplus4W to form the link value (PC+8, delay slot).
- RESET_COUNT, default 0: reset value of the retired-write counter.

- clk  in  1: single clock; all state updates on its rising edge.
- reset  in  1: synchronous, active-high. Clears all GPRs and the counter.
- RegWriteW  in  1: W-stage write enable.
- MemtoRegW  in  1: selects dmRDW as write data.
- dmRDW  in  32: data-memory read word.
- ALUresultW  in  32: ALU result.
- WriteRegW  in  5: destination register index, used as-is; upstream sets 31 for link instructions.
- PCplus4W  in  32: PC+4 of the W-stage instruction.
- jalW, jalrW, bgezalrW  in  1 each: link-instruction flags.
- A1D, A2D  in  5: D-stage read addresses.
- RD1D, RD2D  out  32: D-stage read data, bypassed.
- WDW  out  32: selected writeback data, combinational; sent to the hazard/forwarding network.
- wb_count  out  32: number of committed nonzero-index writes.

## Operation
- link = jalW | jalrW | bgezalrW.
- Write-data priority:
  - link → PCplus4W + LINK_OFFSET (mod 2^32);
  - else MemtoRegW → dmRDW;
  - else ALUresultW.
- WDW is driven with this value regardless of RegWriteW.
- Commit condition: RegWriteW && WriteRegW != 0.
  - On commit: GPR[WriteRegW] <= WDW and wb_count <= wb_count + 1, wrapping 0xFFFFFFFF → 0.
  - Writes to $0 are discarded and do not increment the counter.
- Read ports (each independent):
  - index 0 → 0;
  - else if the commit condition holds and the index == WriteRegW → WDW (bypass);
  - else GPR[index].
- Both ports may read the same register. Both may hit the bypass simultaneously.
- Reset wins over any simultaneous write.
  - After the reset edge: all GPRs = 0, wb_count = RESET_COUNT.
  - RD1D/RD2D then read 0 unless a bypass is active.
- Reset has no pipeline state to drain; a write presented during the reset cycle is lost.
- GPR $0 is never stored. It reads 0 by construction, not by relying on reset.

## Timing
- Write latency: a value presented in cycle N is stored at the edge ending cycle N and visible from the array in cycle N+1.
- It is also visible combinationally through the bypass in cycle N.
- Read path is purely combinational from A1D/A2D and the W-stage inputs; there is no registered output.
- wb_count updates on the same edge as the GPR write.
- Reset values of outputs:
  - RD1D/RD2D = 0, or the bypassed WDW;
  - WDW = combinational function of its inputs;
  - wb_count = RESET_COUNT.
- No handshake; one write per cycle maximum. Stall/flush is handled upstream by zeroing RegWriteW.

## Structure
- Shared package holds:
  - REG_ZERO = 5'd0, REG_RA = 5'd31;
  - GPR_COUNT = 32, DATA_W = 32;
  - default LINK_OFFSET.
- One sub-module is natural: wb_data_sel, the combinational three-way write-data mux (link / mem / ALU) producing WDW.
- The array, bypass, and counter stay in wb_grf.

## Test plan
- Reset, then read all 32 indices on both ports → all 0; wb_count = 0.
- ALU write: RegWriteW=1, WriteRegW=8, ALUresultW=0x1234ABCD, A1D=8 in the same cycle → RD1D=0x1234ABCD via bypass. Next cycle with RegWriteW=0 → RD1D still 0x1234ABCD; wb_count=1.
- Link priority: jalW=1, MemtoRegW=1, PCplus4W=0x00003004, WriteRegW=31 → WDW=0x00003008, GPR31=0x00003008.
- $0 protection: RegWriteW=1, WriteRegW=0, ALUresultW=0xFFFFFFFF → RD1D(A1D=0)=0; wb_count unchanged.
- Reset mid-write: GPR5=0x55 from earlier; assert reset together with a write of 0x77 to $5 → next cycle GPR5 = 0, wb_count = 0.
- Counter wrap: RESET_COUNT=0xFFFFFFFF, one commit → wb_count = 0. Mem select: MemtoRegW=1, dmRDW=0xDEADBEEF, WriteRegW=9 → GPR9=0xDEADBEEF.

Source files
------------

// File: rtl/wb_grf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_grf_pkg
// Purpose  : Shared constants for the writeback stage / general register file.
//            Register-index aliases, array geometry and the default link offset.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package wb_grf_pkg;

    localparam int          DATA_W    = 32;
    localparam int          GPR_COUNT = 32;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [4:0]  REG_RA    = 5'd31;

    // Link value is PC+8: PCplus4W already carries +4, the delay slot adds 4.
    localparam logic [DATA_W-1:0] LINK_OFFSET_DEFAULT = 32'd4;

endpackage : wb_grf_pkg
`default_nettype wire

// File: rtl/wb_grf_wb_data_sel.sv
`default_nettype none
// ============================================================================
// Module   : wb_data_sel
// Purpose  : Combinational writeback-data mux. Link instructions take priority,
//            then memory loads, otherwise the ALU result.
// Ports    : jalW/jalrW/bgezalrW - link flags        (in,  1)
//            MemtoRegW           - memory select      (in,  1)
//            PCplus4W            - PC+4 of W instr    (in, 32)
//            dmRDW               - memory read word   (in, 32)
//            ALUresultW          - ALU result         (in, 32)
//            WDW                 - selected data      (out,32)
// Revision : 1.0 - initial release
// ============================================================================
module wb_data_sel
    import wb_grf_pkg::*;
#(
    parameter logic [DATA_W-1:0] LINK_OFFSET = LINK_OFFSET_DEFAULT
) (
    input  logic              jalW,
    input  logic              jalrW,
    input  logic              bgezalrW,
    input  logic              MemtoRegW,
    input  logic [DATA_W-1:0] PCplus4W,
    input  logic [DATA_W-1:0] dmRDW,
    input  logic [DATA_W-1:0] ALUresultW,
    output logic [DATA_W-1:0] WDW
);

    logic w_link;

    assign w_link = jalW | jalrW | bgezalrW;

    always_comb begin
        WDW = ALUresultW;
        if (w_link) begin
            // Modular add: wraps naturally at 2^32.
            WDW = PCplus4W + LINK_OFFSET;
        end else if (MemtoRegW) begin
            WDW = dmRDW;
        end
    end

endmodule : wb_data_sel
`default_nettype wire

// File: rtl/wb_grf.sv
`default_nettype none
// ============================================================================
// Module   : wb_grf
// Purpose  : Writeback stage merged with the 32x32 general register file.
//            Selects writeback data, commits it on the rising edge, serves two
//            D-stage read ports with write-through bypass, and counts retired
//            nonzero-index writes.
// Ports    : clk, reset           - clock, sync active-high reset (in, 1)
//            RegWriteW            - W-stage write enable          (in, 1)
//            MemtoRegW            - memory data select            (in, 1)
//            dmRDW, ALUresultW    - data sources                  (in, 32)
//            WriteRegW            - destination index             (in, 5)
//            PCplus4W             - PC+4 of W instruction         (in, 32)
//            jalW/jalrW/bgezalrW  - link flags                    (in, 1)
//            A1D, A2D             - read addresses                (in, 5)
//            RD1D, RD2D           - bypassed read data            (out,32)
//            WDW                  - selected writeback data       (out,32)
//            wb_count             - committed write counter       (out,32)
// Revision : 1.0 - initial release
// ============================================================================
module wb_grf
    import wb_grf_pkg::*;
#(
    parameter logic [DATA_W-1:0] LINK_OFFSET = LINK_OFFSET_DEFAULT,
    parameter logic [DATA_W-1:0] RESET_COUNT = 32'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteW,
    input  logic              MemtoRegW,
    input  logic [DATA_W-1:0] dmRDW,
    input  logic [DATA_W-1:0] ALUresultW,
    input  logic [4:0]        WriteRegW,
    input  logic [DATA_W-1:0] PCplus4W,
    input  logic              jalW,
    input  logic              jalrW,
    input  logic              bgezalrW,
    input  logic [4:0]        A1D,
    input  logic [4:0]        A2D,
    output logic [DATA_W-1:0] RD1D,
    output logic [DATA_W-1:0] RD2D,
    output logic [DATA_W-1:0] WDW,
    output logic [DATA_W-1:0] wb_count
);

    // $0 has no storage; the array starts at index 1.
    logic [DATA_W-1:0] r_gpr [1:GPR_COUNT-1];
    logic [DATA_W-1:0] r_count;
    logic              w_commit;

    wb_data_sel #(
        .LINK_OFFSET (LINK_OFFSET)
    ) u_wb_data_sel (
        .jalW       (jalW),
        .jalrW      (jalrW),
        .bgezalrW   (bgezalrW),
        .MemtoRegW  (MemtoRegW),
        .PCplus4W   (PCplus4W),
        .dmRDW      (dmRDW),
        .ALUresultW (ALUresultW),
        .WDW        (WDW)
    );

    assign w_commit = RegWriteW && (WriteRegW != REG_ZERO);

    // Reset takes priority; a write presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < GPR_COUNT; i++) begin
                r_gpr[i] <= '0;
            end
            r_count <= RESET_COUNT;
        end else if (w_commit) begin
            r_gpr[WriteRegW] <= WDW;
            r_count          <= r_count + 32'd1;
        end
    end

    assign wb_count = r_count;

    // Read ports: $0 is hard zero, then same-cycle bypass, then the array.
    always_comb begin
        RD1D = '0;
        if (A1D != REG_ZERO) begin
            if (w_commit && (A1D == WriteRegW)) begin
                RD1D = WDW;
            end else begin
                RD1D = r_gpr[A1D];
            end
        end
    end

    always_comb begin
        RD2D = '0;
        if (A2D != REG_ZERO) begin
            if (w_commit && (A2D == WriteRegW)) begin
                RD2D = WDW;
            end else begin
                RD2D = r_gpr[A2D];
            end
        end
    end

endmodule : wb_grf
`default_nettype wire

// File: tb/tb_wb_grf.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_grf
// Purpose  : Directed self-checking bench for wb_grf. A second instance with
//            RESET_COUNT = 0xFFFFFFFF shares the stimulus to exercise the
//            counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_grf;

    logic        clk;
    logic        reset;
    logic        RegWriteW;
    logic        MemtoRegW;
    logic [31:0] dmRDW;
    logic [31:0] ALUresultW;
    logic [4:0]  WriteRegW;
    logic [31:0] PCplus4W;
    logic        jalW;
    logic        jalrW;
    logic        bgezalrW;
    logic [4:0]  A1D;
    logic [4:0]  A2D;
    logic [31:0] RD1D, RD2D, WDW, wb_count;
    logic [31:0] w_rd1B, w_rd2B, w_wdB, w_countB;

    int checks = 0;
    int errors = 0;

    wb_grf dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .dmRDW      (dmRDW),
        .ALUresultW (ALUresultW),
        .WriteRegW  (WriteRegW),
        .PCplus4W   (PCplus4W),
        .jalW       (jalW),
        .jalrW      (jalrW),
        .bgezalrW   (bgezalrW),
        .A1D        (A1D),
        .A2D        (A2D),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .WDW        (WDW),
        .wb_count   (wb_count)
    );

    wb_grf #(
        .RESET_COUNT (32'hFFFF_FFFF)
    ) dutWrap (
        .clk        (clk),
        .reset      (reset),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .dmRDW      (dmRDW),
        .ALUresultW (ALUresultW),
        .WriteRegW  (WriteRegW),
        .PCplus4W   (PCplus4W),
        .jalW       (jalW),
        .jalrW      (jalrW),
        .bgezalrW   (bgezalrW),
        .A1D        (A1D),
        .A2D        (A2D),
        .RD1D       (w_rd1B),
        .RD2D       (w_rd2B),
        .WDW        (w_wdB),
        .wb_count   (w_countB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegWriteW  = 1'b0;
        MemtoRegW  = 1'b0;
        jalW       = 1'b0;
        jalrW      = 1'b0;
        bgezalrW   = 1'b0;
        dmRDW      = 32'h0;
        ALUresultW = 32'h0;
        PCplus4W   = 32'h0;
        WriteRegW  = 5'd0;
    endtask

    initial begin
        idle();
        A1D   = 5'd0;
        A2D   = 5'd0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state: every index reads zero on both ports.
        for (int i = 0; i < 32; i++) begin
            A1D = 5'(i);
            A2D = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1[%0d]", i), RD1D, 32'h0);
            check($sformatf("reset_rd2[%0d]", 31 - i), RD2D, 32'h0);
        end
        check("reset_count", wb_count, 32'h0);
        check("reset_count_wrap", w_countB, 32'hFFFF_FFFF);

        // ALU write to $8 with same-cycle bypass.
        RegWriteW  = 1'b1;
        WriteRegW  = 5'd8;
        ALUresultW = 32'h1234_ABCD;
        A1D        = 5'd8;
        A2D        = 5'd9;
        #1;
        check("alu_bypass_rd1", RD1D, 32'h1234_ABCD);
        check("alu_wdw", WDW, 32'h1234_ABCD);
        check("alu_nobypass_rd2", RD2D, 32'h0);
        tick();
        idle();
        #1;
        check("alu_stored_rd1", RD1D, 32'h1234_ABCD);
        check("alu_count", wb_count, 32'd1);
        check("wrap_count", w_countB, 32'h0);

        // Link priority over memory select.
        RegWriteW = 1'b1;
        jalW      = 1'b1;
        MemtoRegW = 1'b1;
        dmRDW     = 32'h1111_1111;
        ALUresultW = 32'h2222_2222;
        PCplus4W  = 32'h0000_3004;
        WriteRegW = 5'd31;
        A2D       = 5'd31;
        #1;
        check("link_wdw", WDW, 32'h0000_3008);
        check("link_bypass_rd2", RD2D, 32'h0000_3008);
        tick();
        idle();
        #1;
        check("link_stored_rd2", RD2D, 32'h0000_3008);
        check("link_count", wb_count, 32'd2);

        // bgezalr with PC near the top wraps the link value.
        bgezalrW = 1'b1;
        PCplus4W = 32'hFFFF_FFFE;
        #1;
        check("link_wrap_wdw", WDW, 32'h0000_0002);
        idle();

        // Both ports bypass the same register at once.
        RegWriteW  = 1'b1;
        WriteRegW  = 5'd12;
        ALUresultW = 32'h0000_A5A5;
        A1D        = 5'd12;
        A2D        = 5'd12;
        #1;
        check("dual_bypass_rd1", RD1D, 32'h0000_A5A5);
        check("dual_bypass_rd2", RD2D, 32'h0000_A5A5);
        tick();
        idle();

        // Writes to $0 are discarded and not counted.
        RegWriteW  = 1'b1;
        WriteRegW  = 5'd0;
        ALUresultW = 32'hFFFF_FFFF;
        A1D        = 5'd0;
        A2D        = 5'd12;
        #1;
        check("zero_rd1", RD1D, 32'h0);
        check("zero_wdw", WDW, 32'hFFFF_FFFF);
        check("zero_rd2_unaffected", RD2D, 32'h0000_A5A5);
        tick();
        idle();
        #1;
        check("zero_rd1_after", RD1D, 32'h0);
        check("zero_count", wb_count, 32'd3);

        // Memory select.
        RegWriteW  = 1'b1;
        MemtoRegW  = 1'b1;
        dmRDW      = 32'hDEAD_BEEF;
        ALUresultW = 32'h0000_0001;
        WriteRegW  = 5'd9;
        #1;
        check("mem_wdw", WDW, 32'hDEAD_BEEF);
        tick();
        idle();
        A1D = 5'd9;
        #1;
        check("mem_stored_rd1", RD1D, 32'hDEAD_BEEF);
        check("mem_count", wb_count, 32'd4);

        // RegWriteW low: no bypass, no store, even with matching index.
        WriteRegW  = 5'd8;
        ALUresultW = 32'h0BAD_0BAD;
        A1D        = 5'd8;
        #1;
        check("nowrite_nobypass", RD1D, 32'h1234_ABCD);
        check("nowrite_wdw", WDW, 32'h0BAD_0BAD);
        tick();
        idle();
        #1;
        check("nowrite_unchanged", RD1D, 32'h1234_ABCD);
        check("nowrite_count", wb_count, 32'd4);

        // Reset wins over a simultaneous write.
        RegWriteW  = 1'b1;
        WriteRegW  = 5'd5;
        ALUresultW = 32'h0000_0055;
        tick();
        idle();
        A1D = 5'd5;
        #1;
        check("pre_reset_rd1", RD1D, 32'h0000_0055);
        check("pre_reset_count", wb_count, 32'd5);
        reset      = 1'b1;
        RegWriteW  = 1'b1;
        WriteRegW  = 5'd5;
        ALUresultW = 32'h0000_0077;
        tick();
        reset = 1'b0;
        idle();
        A1D = 5'd5;
        A2D = 5'd8;
        #1;
        check("mid_reset_rd1", RD1D, 32'h0);
        check("mid_reset_rd2", RD2D, 32'h0);
        check("mid_reset_count", wb_count, 32'h0);
        check("mid_reset_count_wrap", w_countB, 32'hFFFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule : tb_wb_grf
`default_nettype wire
